// File: rtl/jtag_scan_master.sv
// -----------------------------------------------------------------------------
// jtag_scan_master
//
// Host-side JTAG engine. Accepts one command at a time (TAP reset, IR scan,
// DR scan or idle clocking), generates jtag_tck/jtag_tms/jtag_tdi, samples
// jtag_tdo, and returns one response per command. The target TAP is assumed
// to sit in Run-Test/Idle between commands.
//
// Ports:
//   tck        system clock, all logic on its rising edge
//   reset      synchronous, active-high reset
//   cmd_*      command channel (valid/ready); type 00 RESET, 01 IR_SCAN,
//              10 DR_SCAN, 11 IDLE; len = shift length or RTI clock count;
//              data = TDI bits, LSB shifted first
//   rsp_*      response channel (valid/ready); data = captured TDO bits
//   busy       a command is executing
//   jtag_tck/jtag_tms/jtag_tdi  outputs to the target TAP
//   jtag_tdo   input from the target TAP
//
// Optional build macro:
//   JTAG_SCAN_MASTER_AUTO_RESET_EN  run a silent Test-Logic-Reset sequence on
//   the first cycle after reset releases. In that build cmd_ready is held low
//   under reset so no command can slip in ahead of the autonomous sequence.
// -----------------------------------------------------------------------------
module jtag_scan_master #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CLK_DIV = 2
) (
    input  logic               tck,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo
);

    localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

`ifdef JTAG_SCAN_MASTER_AUTO_RESET_EN
    localparam logic READY_RST = 1'b0;
`else
    localparam logic READY_RST = 1'b1;
`endif

    // Bit states are named after the TAP state the target is in when
    // jtag_tck rises for that bit; jtag_tms is the value that steers it on.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TLR,        // five TMS 1 bits then TMS 0
        ST_RTI,        // TMS 1 -> Select-DR
        ST_SEL_DR,     // TMS 1 -> Select-IR (IR scan) / TMS 0 -> Capture-DR
        ST_SEL_IR,     // TMS 0 -> Capture-IR
        ST_CAPTURE,    // TMS 0 -> Shift, or TMS 1 -> Exit1 for a zero-length scan
        ST_SHIFT,      // data bits, last one with TMS 1 -> Exit1
        ST_EXIT1,      // TMS 1 -> Update
        ST_UPDATE,     // TMS 0 -> Run-Test/Idle
        ST_IDLE_CLK,   // TMS 0 clocks in Run-Test/Idle
        ST_DONE,       // one settling cycle before the response appears
        ST_RESP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_idx;
    logic [CNT_W-1:0]   len_q;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] cap_q;
    logic               is_ir;
    logic [DIV_W-1:0]   div_cnt;
`ifdef JTAG_SCAN_MASTER_AUTO_RESET_EN
    logic               auto_pend;
    logic               silent;
`endif

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(MAX_LEN)) begin
            return LEN_W'(MAX_LEN);
        end
        return len;
    endfunction

    logic [CNT_W-1:0] nidx;
    logic             last_bit;
    logic             len_zero;
    logic             phase_end;
    logic             sample_tdo;

    always_comb begin
        nidx       = bit_idx + CNT_W'(1);
        last_bit   = (bit_idx == (len_q - CNT_W'(1)));
        len_zero   = (len_q == '0);
        phase_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
        // TDO is stable for the whole high phase; take it in its first cycle.
        sample_tdo = (state == ST_SHIFT) && jtag_tck && (div_cnt == '0);
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            state     <= ST_IDLE;
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
            cmd_ready <= READY_RST;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            div_cnt   <= '0;
            bit_idx   <= '0;
`ifdef JTAG_SCAN_MASTER_AUTO_RESET_EN
            auto_pend <= 1'b1;
            silent    <= 1'b0;
`endif
        end else begin
            case (state)
                // ---- command acceptance: bit 0 TMS/TDI appear next cycle ----
                ST_IDLE: begin
                    div_cnt  <= '0;
                    jtag_tck <= 1'b0;
`ifdef JTAG_SCAN_MASTER_AUTO_RESET_EN
                    if (auto_pend) begin
                        auto_pend <= 1'b0;
                        silent    <= 1'b1;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        cap_q     <= '0;
                        bit_idx   <= '0;
                        jtag_tdi  <= 1'b0;
                        jtag_tms  <= 1'b1;
                        state     <= ST_TLR;
                    end else
`endif
                    if (cmd_valid && cmd_ready) begin
                        len_q     <= CNT_W'(sat_len(cmd_len));
                        data_q    <= cmd_data;
                        is_ir     <= (cmd_type == 2'b01);
                        cap_q     <= '0;
                        bit_idx   <= '0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        jtag_tdi  <= 1'b0;
                        case (cmd_type)
                            2'b00: begin
                                state    <= ST_TLR;
                                jtag_tms <= 1'b1;
                            end
                            2'b01, 2'b10: begin
                                state    <= ST_RTI;
                                jtag_tms <= 1'b1;
                            end
                            default: begin
                                jtag_tms <= 1'b0;
                                state    <= (sat_len(cmd_len) == '0) ? ST_DONE : ST_IDLE_CLK;
                            end
                        endcase
                    end
                end

                // ---- completion: publish response one cycle after the last bit ----
                ST_DONE: begin
                    busy <= 1'b0;
`ifdef JTAG_SCAN_MASTER_AUTO_RESET_EN
                    if (silent) begin
                        silent    <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else
`endif
                    begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap_q;
                        state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                // ---- bit engine: TCK divider, TDO sample, next-bit on falling edge ----
                default: begin
                    if (sample_tdo) begin
                        cap_q[bit_idx[IDX_W-1:0]] <= jtag_tdo;
                    end
                    if (phase_end) begin
                        div_cnt  <= '0;
                        jtag_tck <= ~jtag_tck;
                        if (jtag_tck) begin
                            case (state)
                                ST_TLR: begin
                                    if (bit_idx == CNT_W'(5)) begin
                                        jtag_tms <= 1'b0;
                                        state    <= ST_DONE;
                                    end else begin
                                        bit_idx  <= nidx;
                                        jtag_tms <= (nidx != CNT_W'(5));
                                    end
                                end
                                ST_RTI: begin
                                    jtag_tms <= is_ir;
                                    state    <= ST_SEL_DR;
                                end
                                ST_SEL_DR: begin
                                    if (is_ir) begin
                                        jtag_tms <= 1'b0;
                                        state    <= ST_SEL_IR;
                                    end else begin
                                        jtag_tms <= len_zero;
                                        state    <= ST_CAPTURE;
                                    end
                                end
                                ST_SEL_IR: begin
                                    jtag_tms <= len_zero;
                                    state    <= ST_CAPTURE;
                                end
                                ST_CAPTURE: begin
                                    if (len_zero) begin
                                        jtag_tms <= 1'b1;
                                        state    <= ST_EXIT1;
                                    end else begin
                                        bit_idx  <= '0;
                                        jtag_tms <= (len_q == CNT_W'(1));
                                        jtag_tdi <= data_q[0];
                                        state    <= ST_SHIFT;
                                    end
                                end
                                ST_SHIFT: begin
                                    if (last_bit) begin
                                        jtag_tms <= 1'b1;
                                        jtag_tdi <= 1'b0;
                                        state    <= ST_EXIT1;
                                    end else begin
                                        bit_idx  <= nidx;
                                        jtag_tms <= (nidx == (len_q - CNT_W'(1)));
                                        jtag_tdi <= data_q[nidx[IDX_W-1:0]];
                                    end
                                end
                                ST_EXIT1: begin
                                    jtag_tms <= 1'b0;
                                    state    <= ST_UPDATE;
                                end
                                ST_UPDATE: begin
                                    jtag_tms <= 1'b0;
                                    state    <= ST_DONE;
                                end
                                ST_IDLE_CLK: begin
                                    jtag_tms <= 1'b0;
                                    if (last_bit) begin
                                        state <= ST_DONE;
                                    end else begin
                                        bit_idx <= nidx;
                                    end
                                end
                                default: begin
                                    jtag_tms <= 1'b0;
                                    state    <= ST_IDLE;
                                end
                            endcase
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
